// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared decoder constants and helpers
package ecc_pkg;

  localparam int ECC_LOC_W = 10;
  localparam logic [ECC_LOC_W-1:0] ECC_NULL_LOC = '1;

  typedef enum logic [0:0] {
    SRC_CAND = 1'b0,
    SRC_ES   = 1'b1
  } burst_src_e;

  // Ceiling log2, never below 1 so derived ports always have a legal width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/loc_burst_buf.sv
// rtl/loc_burst_buf.sv - latched location slots plus burst read pointer
module loc_burst_buf #(
  parameter int               LOC_W    = 10,
  parameter int               MAX_ERR  = 6,
  parameter int               PTR_W    = 3,
  parameter logic [LOC_W-1:0] NULL_LOC = '1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [MAX_ERR*LOC_W-1:0] i_load_loc,
  input  logic                     i_adv,
  output logic [PTR_W-1:0]         o_ptr,
  output logic [LOC_W-1:0]         o_nxt_loc
);

  logic [LOC_W-1:0] loc_q [MAX_ERR];
  logic [PTR_W-1:0] nxt_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < MAX_ERR; k++) begin
        loc_q[k] <= NULL_LOC;
      end
      o_ptr <= '0;
    end else if (i_load) begin
      for (int k = 0; k < MAX_ERR; k++) begin
        loc_q[k] <= i_load_loc[k*LOC_W +: LOC_W];
      end
      o_ptr <= '0;
    end else if (i_adv) begin
      o_ptr <= o_ptr + PTR_W'(1);
    end
  end

  // Look-ahead slot so the top can register the following beat on a handshake.
  assign nxt_idx = o_ptr + PTR_W'(1);

  always_comb begin
    o_nxt_loc = NULL_LOC;
    for (int k = 0; k < MAX_ERR; k++) begin
      if (nxt_idx == PTR_W'(k)) begin
        o_nxt_loc = loc_q[k];
      end
    end
  end

endmodule

// File: rtl/err_loc_streamer.sv
// rtl/err_loc_streamer.sv - streams latched error locations as handshaked bursts
module err_loc_streamer
  import ecc_pkg::*;
#(
  parameter int               LOC_W    = ECC_LOC_W,
  parameter int               MAX_ERR  = 6,
  parameter int               NUM_CAND = 4,
  parameter int               NUM_ES   = 2,
  parameter logic [LOC_W-1:0] NULL_LOC = {LOC_W{1'b1}},
  localparam int              CNT_W    = clog2(MAX_ERR + 1),
  localparam int              SEL_W    = clog2(NUM_CAND),
  localparam int              ESN_W    = clog2(NUM_ES + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_cand_valid,
  input  logic [SEL_W-1:0]                  i_cand_sel,
  input  logic [NUM_CAND*MAX_ERR*LOC_W-1:0] i_cand_loc,
  input  logic [NUM_CAND*CNT_W-1:0]         i_cand_num,
  input  logic                              i_es_valid,
  input  logic [ESN_W-1:0]                  i_es_num,
  input  logic [NUM_ES*LOC_W-1:0]           i_es_loc,
  output logic                              o_in_ready,
  output logic                              o_drop,
  output logic [LOC_W-1:0]                  o_loc,
  output logic                              o_valid,
  output logic                              o_last,
  input  logic                              i_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         ptr;
  logic [LOC_W-1:0]         nxt_loc;
  logic                     req;
  logic                     accept;
  logic                     hs;
  logic                     last_next;
  burst_src_e               ld_src;
  logic [CNT_W-1:0]         ld_cnt;
  logic [CNT_W-1:0]         cand_raw;
  logic [MAX_ERR*LOC_W-1:0] ld_loc;

  assign req        = i_es_valid | i_cand_valid;
  assign o_in_ready = (state == ST_IDLE) | (o_valid & o_last & i_ready);
  assign accept     = req & o_in_ready;
  assign hs         = o_valid & i_ready;
  assign last_next  = ({1'b0, ptr} + (CNT_W+1)'(2)) >= {1'b0, cnt};

  // Early-stop has priority; a simultaneous candidate request is silently discarded.
  always_comb begin
    ld_src   = i_es_valid ? SRC_ES : SRC_CAND;
    ld_cnt   = '0;
    cand_raw = '0;
    ld_loc   = {MAX_ERR{NULL_LOC}};
    if (ld_src == SRC_ES) begin
      ld_cnt = (i_es_num > ESN_W'(NUM_ES)) ? CNT_W'(NUM_ES) : CNT_W'(i_es_num);
      for (int k = 0; k < NUM_ES; k++) begin
        ld_loc[k*LOC_W +: LOC_W] = i_es_loc[k*LOC_W +: LOC_W];
      end
    end else begin
      for (int c = 0; c < NUM_CAND; c++) begin
        if (i_cand_sel == SEL_W'(c)) begin
          cand_raw = i_cand_num[c*CNT_W +: CNT_W];
          ld_cnt   = (cand_raw > CNT_W'(MAX_ERR)) ? CNT_W'(MAX_ERR) : cand_raw;
          ld_loc   = i_cand_loc[c*MAX_ERR*LOC_W +: MAX_ERR*LOC_W];
        end
      end
    end
  end

  loc_burst_buf #(
    .LOC_W    (LOC_W),
    .MAX_ERR  (MAX_ERR),
    .PTR_W    (CNT_W),
    .NULL_LOC (NULL_LOC)
  ) u_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (accept),
    .i_load_loc (ld_loc),
    .i_adv      (hs & ~o_last),
    .o_ptr      (ptr),
    .o_nxt_loc  (nxt_loc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_loc   <= NULL_LOC;
      o_drop  <= 1'b0;
    end else begin
      o_drop <= req & ~o_in_ready;
      if (accept) begin
        state   <= ST_EMIT;
        cnt     <= ld_cnt;
        o_valid <= 1'b1;
        o_loc   <= (ld_cnt == '0) ? NULL_LOC : ld_loc[LOC_W-1:0];
        o_last  <= (ld_cnt <= CNT_W'(1));
      end else if (hs) begin
        if (o_last) begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_loc   <= NULL_LOC;
          o_last  <= 1'b0;
        end else begin
          o_loc  <= nxt_loc;
          o_last <= last_next;
        end
      end
    end
  end

endmodule

// File: doc/err_loc_streamer.md
ERR_LOC_STREAMER -- requirements
Module: err_loc_streamer

Interface
REQ-001 Parameter LOC_W, default 10: bit width of one error location.
REQ-002 Parameter MAX_ERR, default 6: maximum number of locations per codeword.
REQ-003 Parameter NUM_CAND, default 4: number of candidate (test-pattern) channels.
REQ-004 Parameter NUM_ES, default 2: number of early-stop flip positions.
REQ-005 Parameter NULL_LOC, default 2**LOC_W-1: location value meaning "no error".
REQ-006 Derived widths: CNT_W = clog2(MAX_ERR+1); SEL_W = clog2(NUM_CAND).
REQ-007 i_clk  input  1  single clock; all state is updated on its rising edge.
REQ-008 i_rst  input  1  reset, asynchronous and active-high.
REQ-009 i_cand_valid  input  1  candidate-result request pulse.
REQ-010 i_cand_sel  input  SEL_W  index of the winning candidate.
REQ-011 i_cand_loc  input  NUM_CAND*MAX_ERR*LOC_W  flattened locations; candidate c, slot k sits at index (c*MAX_ERR+k).
REQ-012 i_cand_num  input  NUM_CAND*CNT_W  flattened error count per candidate.
REQ-013 i_es_valid  input  1  early-stop request pulse.
REQ-014 i_es_num  input  clog2(NUM_ES+1)  number of valid flip positions.
REQ-015 i_es_loc  input  NUM_ES*LOC_W  flattened flip positions.
REQ-016 o_in_ready  output  1  a request is accepted in this cycle.
REQ-017 o_drop  output  1  one-cycle pulse: a request arrived while o_in_ready was low.
REQ-018 o_loc  output  LOC_W  streamed error location.
REQ-019 o_valid  output  1  o_loc is valid.
REQ-020 o_last  output  1  the current beat is the final beat of its burst.
REQ-021 i_ready  input  1  downstream accepts the beat when o_valid && i_ready.

Function
REQ-022 FSM states: IDLE and EMIT. o_in_ready is high in IDLE, and in EMIT when o_valid && o_last && i_ready.
REQ-023 Accept rule: a request is accepted when (i_es_valid || i_cand_valid) && o_in_ready. If both requests are valid in the same cycle, early-stop wins and the candidate request is discarded without asserting o_drop.
REQ-024 On accept, the block latches the burst source into internal buffers: for a candidate request, slots 0..MAX_ERR-1 of candidate i_cand_sel and that candidate's count; for an early-stop request, i_es_loc and i_es_num.
REQ-025 Latched counts saturate at MAX_ERR for candidates and at NUM_ES for early-stop.
REQ-026 If i_cand_sel >= NUM_CAND, the latched count is 0.
REQ-027 Burst length is max(count,1). A count of 0 emits exactly one beat with o_loc=NULL_LOC and o_last=1.
REQ-028 Latency: the request is accepted at edge N; the first beat has o_valid=1 starting immediately after edge N. Outputs are registered.
REQ-029 Beat k carries slot k. The beat index advances only on a handshake (o_valid && i_ready).
REQ-030 Under backpressure (o_valid && !i_ready), o_loc, o_valid and o_last are held stable.
REQ-031 After the last handshake: if a request is accepted in the same cycle, the next burst starts with no bubble; otherwise the FSM returns to IDLE with o_valid=0 and o_loc=NULL_LOC.
REQ-032 A request while o_in_ready=0 is ignored, pulses o_drop for one cycle, and leaves the current burst unaffected.
REQ-033 While o_valid=0, o_loc=NULL_LOC and o_last=0.

Reset
REQ-034 i_rst asserts all state immediately: FSM=IDLE, beat index=0, buffers=NULL_LOC, counts=0, o_valid=0, o_last=0, o_drop=0, o_loc=NULL_LOC.
REQ-035 Reset during EMIT abandons the burst. No beat is produced after reset deasserts until a new request is accepted.

Structure
REQ-036 NULL_LOC, the default LOC_W and the clog2 function live in the shared ecc_pkg package, alongside the other decoder constants.
REQ-037 The location buffer and beat index are placed in one sub-module, loc_burst_buf (MAX_ERR x LOC_W registers plus a read pointer). The FSM and source selection remain in the top level.

Verification
REQ-038 Candidate request with sel=2, num=3, locs {5,17,900}, i_ready=1 -> beats 5, 17, 900 on consecutive cycles; o_last on the 900 beat.
REQ-039 Candidate request with num=0 -> a single beat with o_loc=1023 and o_last=1.
REQ-040 i_es_valid and i_cand_valid in the same cycle, es num=2, locs {40,41} -> beats 40 then 41; no candidate beats; o_drop=0.
REQ-041 Burst with num=6; i_ready low for 3 cycles at beat 2 -> beat 2 held stable for 3 cycles; all 6 beats delivered in order.
REQ-042 Second request arrives mid-burst -> o_drop pulses once; the first burst is intact. A request on the last handshake -> the next burst begins with no idle cycle.
REQ-043 i_rst asserted mid-burst at beat 1 -> o_valid=0 and o_loc=1023 immediately; no further beats after release.
